// File: rtl/branch_seq_ctrl.sv
// Multicycle branch sequencer: target add, rs-rt compare, flag sample, conditional PC write.
// Optional br_total/br_taken statistics counters are built when BRANCH_STATS_EN is defined.
module branch_seq_ctrl #(
    parameter int unsigned ALU_LAT  = 1,
    parameter logic [2:0]  OP_ADD   = 3'b001,
    parameter logic [2:0]  OP_SUB   = 3'b010,
    parameter logic [1:0]  PCSRC_BR = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  cond,
    input  logic        flush,
    input  logic        flag_in,
    output logic [1:0]  ALUflag,
    output logic [2:0]  alu_op,
    output logic        alu_srcA,
    output logic        alu_srcB,
    output logic [1:0]  pc_src,
    output logic        pc_write,
    output logic        busy,
    output logic        done,
    output logic        taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] br_total,
    output logic [15:0] br_taken
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC_TGT,
        S_COMPARE,
        S_WAIT,
        S_EVAL,
        S_WRITE,
        S_DONE
    } state_t;

    generate
        if (ALU_LAT == 0 || ALU_LAT > 15) begin : g_bad_alu_lat
            $error("branch_seq_ctrl: ALU_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  alu_flag_q, alu_flag_d;
    logic        taken_q, taken_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        alu_src_a_q, alu_src_a_d;
    logic        alu_src_b_q, alu_src_b_d;
    logic [1:0]  pc_src_q, pc_src_d;
    logic        pc_write_q, pc_write_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Sequencing; the flag select register is only reloaded when a new branch is accepted
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_flag_d = alu_flag_q;
        taken_d    = taken_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CALC_TGT;
                    alu_flag_d = cond;
                    taken_d    = 1'b0;
                end
            end
            S_CALC_TGT: state_d = S_COMPARE;
            S_COMPARE: begin
                state_d = S_WAIT;
                cnt_d   = LAT_LOAD;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_EVAL: begin
                taken_d = flag_in;
                state_d = flag_in ? S_WRITE : S_DONE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A pc_write already on the outputs stays; only the following states are dropped
        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            taken_d = 1'b0;
        end
    end

    // Moore outputs are decoded from the next state so they register alongside it
    always_comb begin
        alu_op_d    = 3'b000;
        alu_src_a_d = 1'b0;
        alu_src_b_d = 1'b0;
        pc_src_d    = 2'b00;
        pc_write_d  = 1'b0;
        done_d      = 1'b0;
        busy_d      = (state_d != S_IDLE);

        case (state_d)
            S_CALC_TGT: alu_op_d = OP_ADD;
            S_COMPARE: begin
                alu_op_d    = OP_SUB;
                alu_src_a_d = 1'b1;
                alu_src_b_d = 1'b1;
            end
            S_WRITE: begin
                pc_src_d   = PCSRC_BR;
                pc_write_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            alu_flag_q  <= 2'b00;
            taken_q     <= 1'b0;
            alu_op_q    <= 3'b000;
            alu_src_a_q <= 1'b0;
            alu_src_b_q <= 1'b0;
            pc_src_q    <= 2'b00;
            pc_write_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_flag_q  <= alu_flag_d;
            taken_q     <= taken_d;
            alu_op_q    <= alu_op_d;
            alu_src_a_q <= alu_src_a_d;
            alu_src_b_q <= alu_src_b_d;
            pc_src_q    <= pc_src_d;
            pc_write_q  <= pc_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ALUflag  = alu_flag_q;
    assign alu_op   = alu_op_q;
    assign alu_srcA = alu_src_a_q;
    assign alu_srcB = alu_src_b_q;
    assign pc_src   = pc_src_q;
    assign pc_write = pc_write_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign taken    = taken_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] br_total_q, br_total_d;
    logic [15:0] br_taken_q, br_taken_d;

    // Counters step on the same edge that raises done, so they move with the pulse
    always_comb begin
        br_total_d = br_total_q + {15'd0, done_d};
        br_taken_d = br_taken_q + {15'd0, done_d & taken_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_total_q <= 16'd0;
            br_taken_q <= 16'd0;
        end else begin
            br_total_q <= br_total_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign br_total = br_total_q;
    assign br_taken = br_taken_q;
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Randomized bench for branch_seq_ctrl: each branch is predicted from its cycle schedule
// (target, compare, ALU wait, evaluate, optional write, done) and compared cycle by cycle.
module tb_branch_seq_ctrl;

    localparam int unsigned LAT = 3;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] cond;
    logic       flush;
    logic       flag_in;
    logic [1:0] ALUflag;
    logic [2:0] alu_op;
    logic       alu_srcA;
    logic       alu_srcB;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       busy;
    logic       done;
    logic       taken;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_total;
    logic [15:0] br_taken;
`endif

    int compared   = 0;
    int mismatched = 0;
    int expTotal   = 0;
    int expTaken   = 0;

    branch_seq_ctrl #(.ALU_LAT(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cond     (cond),
        .flush    (flush),
        .flag_in  (flag_in),
        .ALUflag  (ALUflag),
        .alu_op   (alu_op),
        .alu_srcA (alu_srcA),
        .alu_srcB (alu_srcB),
        .pc_src   (pc_src),
        .pc_write (pc_write),
        .busy     (busy),
        .done     (done),
        .taken    (taken)
`ifdef BRANCH_STATS_EN
        ,
        .br_total (br_total),
        .br_taken (br_taken)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string where, input bit checkTaken);
        checkOutput({where, " busy"}, 32'(busy), 32'd0);
        checkOutput({where, " pc_write"}, 32'(pc_write), 32'd0);
        checkOutput({where, " done"}, 32'(done), 32'd0);
        checkOutput({where, " alu_op"}, 32'(alu_op), 32'd0);
        checkOutput({where, " pc_src"}, 32'(pc_src), 32'd0);
        if (checkTaken) checkOutput({where, " taken"}, 32'(taken), 32'd0);
`ifdef BRANCH_STATS_EN
        checkOutput({where, " br_total"}, 32'(br_total), 32'(expTotal & 16'hFFFF));
        checkOutput({where, " br_taken"}, 32'(br_taken), 32'(expTaken & 16'hFFFF));
`endif
    endtask

    task automatic checkReset(input string where);
        checkIdle(where, 1'b1);
        checkOutput({where, " ALUflag"}, 32'(ALUflag), 32'd0);
        checkOutput({where, " alu_srcA"}, 32'(alu_srcA), 32'd0);
        checkOutput({where, " alu_srcB"}, 32'(alu_srcB), 32'd0);
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle
    task automatic applyStimulus(input bit doFlush, input int flushAt);
        logic [1:0] condV;
        bit         flagV;
        bit         flushed;
        int         last;
        int         writeCycle;
        string      t;

        condV      = 2'($urandom_range(0, 3));
        flagV      = 1'($urandom_range(0, 1));
        writeCycle = 4 + LAT;
        last       = flagV ? 5 + LAT : 4 + LAT;
        flushed    = 1'b0;
        start      = 1'b1;
        cond       = condV;
        flush      = 1'b0;

        for (int k = 1; k <= last && !flushed; k++) begin
            @(negedge clk);
            t = $sformatf("k=%0d", k);
            checkOutput({t, " busy"}, 32'(busy), 32'd1);
            checkOutput({t, " alu_op"}, 32'(alu_op), 32'((k == 1) ? OP_ADD : (k == 2) ? OP_SUB : 3'b000));
            checkOutput({t, " alu_srcA"}, 32'(alu_srcA), 32'(k == 2));
            checkOutput({t, " alu_srcB"}, 32'(alu_srcB), 32'(k == 2));
            if (k >= 2 && k <= 3 + LAT) checkOutput({t, " ALUflag"}, 32'(ALUflag), 32'(condV));
            checkOutput({t, " pc_write"}, 32'(pc_write), 32'(flagV && k == writeCycle));
            checkOutput({t, " pc_src"}, 32'(pc_src), (flagV && k == writeCycle) ? 32'd1 : 32'd0);
            checkOutput({t, " done"}, 32'(done), 32'(k == last));
            if (k == last) begin
                checkOutput({t, " taken"}, 32'(taken), 32'(flagV));
                expTotal++;
                if (flagV) expTaken++;
            end
            start   = 1'($urandom_range(0, 1));
            cond    = 2'($urandom_range(0, 3));
            flag_in = (k == 3 + LAT) ? flagV : 1'($urandom_range(0, 1));
            if (doFlush && k == flushAt) begin
                flush   = 1'b1;
                flushed = 1'b1;
            end
        end

        @(negedge clk);
        checkIdle(flushed ? "after flush" : "after done", flushed);
        flush = 1'b0;
        start = 1'b0;
    endtask

    task automatic resetMidWait();
        start = 1'b1;
        cond  = 2'($urandom_range(0, 3));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid-wait busy", 32'(busy), 32'd1);
        reset   = 1'b1;
        flag_in = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        expTotal = 0;
        expTaken = 0;
        checkReset("reset mid-wait");
        reset = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        checkReset("after reset release");
    endtask

    task automatic runBranches(input int count);
        int gap;
        for (int i = 0; i < count; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge clk);
                checkOutput("gap busy", 32'(busy), 32'd0);
            end
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(1, 5 + LAT));
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        cond    = 2'b00;
        flush   = 1'b0;
        flag_in = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("reset");
        reset = 1'b0;

        runBranches(60);
        resetMidWait();
        runBranches(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
